async_ctrl_gen: RTL and testbench
=================================

# async_ctrl_gen

Synchronous generator for the asynchronous clear/preset controls that drive downstream async-control flip-flops. Accepts one clear or preset request at a time over a valid/ready handshake and emits a clean pulse of configurable width on exactly one of its two outputs. Deassertion is always synchronous to clk, which meets downstream recovery/removal timing, and is followed by a quiet gap. An optional checker samples the target's q after release and counts wrong results.

## Interface
- PULSE_W, 2, cycles tgt_clr/tgt_pr held high per request; legal range ≥1.
- RELEASE_GAP, 1, idle cycles after deassertion before done; legal range ≥1.
- clk  in  1  clock, all state changes on posedge.
- clr  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_op  in  1  0 = clear, 1 = preset.
- req_ready  out  1  high only in IDLE.
- tgt_clr  out  1  async clear to the target, registered.
- tgt_pr  out  1  async preset to the target, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence completion.
- q_obs  in  1  observed target q, used only by the checker.
- chk_fail  out  1  one-cycle pulse, high together with done when q_obs is wrong.
- fail_cnt  out  8  saturating count of chk_fail pulses.

## Operation
- States are RST_REL, IDLE, ASSERT, GAP.
- While clr is high:
  - tgt_clr is forced to 1 and tgt_pr to 0 immediately. The system reset passes through to the targets.
  - State is RST_REL. req_ready=0, busy=1, done=0, chk_fail=0, fail_cnt=0.
- RST_REL: first posedge after clr falls drives tgt_clr to 0 and enters GAP with op=clear. That GAP completes normally, including done and the check.
- IDLE: a request is accepted on a posedge with req_valid=1 and req_ready=1. req_op is latched and the state moves to ASSERT.
- ASSERT: exactly one of tgt_clr/tgt_pr is high, selected by the latched op, for PULSE_W cycles. Then the state moves to GAP and the output drops.
- GAP: both outputs low for RELEASE_GAP cycles. The exiting edge pulses done, samples q_obs for the check and enters IDLE.
- tgt_clr and tgt_pr are never high together, in any state or during reset.
- req_valid outside IDLE is ignored; requests are not queued. req_op changes after acceptance have no effect.
- Checker expectation: q_obs=0 for clear, q_obs=1 for preset. On a mismatch, chk_fail=1 and fail_cnt increments, saturating at 255.
- Reset mid-sequence aborts the sequence at once: no done and no check for the aborted request.
- Cycle counter width is $clog2(max(PULSE_W,RELEASE_GAP)+1). The counter loads on state entry and transitions at terminal count.

## Timing
- Accept at edge N:
  - tgt_* high after edge N through edge N+PULSE_W.
  - tgt_* low after edge N+PULSE_W.
  - At edge N+PULSE_W+RELEASE_GAP: done=1, req_ready=1, q_obs sampled.
- Earliest next accept is edge N+PULSE_W+RELEASE_GAP+1. Throughput is one request per PULSE_W+RELEASE_GAP+1 cycles.
- Assertion and deassertion of tgt_* are both posedge-registered, so there are no glitches. Only reset asserts tgt_clr asynchronously.
- Latency from accept to done is PULSE_W+RELEASE_GAP cycles.

## Configuration
- ASYNC_CTRL_CHECK_EN defined: the checker is instantiated and chk_fail/fail_cnt operate as described.
- ASYNC_CTRL_CHECK_EN undefined: q_obs is ignored, chk_fail=0 and fail_cnt=0 constantly. The sequencing is cycle-identical in both cases.

## Structure
- Package async_ctrl_pkg holds:
  - state enum: RST_REL, IDLE, ASSERT, GAP.
  - op enum: OP_CLR=0, OP_PR=1.
  - FAIL_CNT_W=8.
- Sub-module async_ctrl_chk holds the expected-value compare, the chk_fail register and the saturating counter. It is instantiated only under ASYNC_CTRL_CHECK_EN.
- Parameter legality (≥1) is checked by an elaboration-time assertion.

## Test plan
- Reset: hold clr high for 3 cycles → tgt_clr=1, tgt_pr=0, req_ready=0. Release clr → tgt_clr=0 on the 1st edge, done on the 2nd edge (defaults), req_ready=1.
- Preset request, defaults, accept at edge 10 → tgt_pr high for cycles 11–12. Edge 13: done=1. With q_obs=1: chk_fail=0, fail_cnt=0.
- Clear request with q_obs stuck at 1 (macro on) → at done, chk_fail=1 and fail_cnt=1. Repeat 300 times → fail_cnt=255.
- req_valid held high with alternating req_op → one accept every 4 cycles, ops in order, tgt_clr and tgt_pr never both high.
- Raise clr during ASSERT of a preset → tgt_pr=0 and tgt_clr=1 in the same cycle. No done for the aborted request. Normal recovery after release.
- PULSE_W=5, RELEASE_GAP=3 → pulse exactly 5 cycles, done 8 cycles after accept. Macro off → chk_fail=0 and fail_cnt=0 throughout.

Source files
------------

// File: rtl/async_ctrl_pkg.sv
// Shared types and constants for the async clear/preset control generator.
package async_ctrl_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      RST_REL = 2'd0,
      IDLE    = 2'd1,
      ASSERT  = 2'd2,
      GAP     = 2'd3
   } state_e;

   // Requested operation on the target flop
   typedef enum logic {
      OP_CLR = 1'b0,
      OP_PR  = 1'b1
   } op_e;

   localparam int unsigned FAIL_CNT_W = 8;

   // Width of a down-counter that must hold max(a, b) - 1 (and tolerate max(a, b))
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/async_ctrl_gen_if.sv
// Request handshake and status bundle of async_ctrl_gen.
interface async_ctrl_gen_if;
   logic req_valid;
   logic req_op;
   logic req_ready;
   logic busy;
   logic done;

   // Requester side
   modport master (
      output req_valid,
      output req_op,
      input  req_ready,
      input  busy,
      input  done
   );

   // Generator side
   modport slave (
      input  req_valid,
      input  req_op,
      output req_ready,
      output busy,
      output done
   );
endinterface

// File: rtl/async_ctrl_chk.sv
// Post-release checker: compares the observed target q with the value the
// completed operation should have produced and keeps a saturating miss count.
module async_ctrl_chk
   import async_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  sample,
   input  op_e                   op,
   input  logic                  q_obs,
   output logic                  chk_fail,
   output logic [FAIL_CNT_W-1:0] fail_cnt
);

   logic                  mismatch;
   logic                  chk_fail_q;
   logic [FAIL_CNT_W-1:0] fail_cnt_q;

   // Clear must leave q=0, preset must leave q=1
   always_comb begin
      mismatch = sample && (q_obs != (op == OP_PR));
   end

   // Fail pulse and saturating counter
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         chk_fail_q <= 1'b0;
         fail_cnt_q <= '0;
      end else begin
         chk_fail_q <= mismatch;
         if (mismatch && (fail_cnt_q != {FAIL_CNT_W{1'b1}})) begin
            fail_cnt_q <= fail_cnt_q + 1'b1;
         end
      end
   end

   assign chk_fail = chk_fail_q;
   assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/async_ctrl_gen.sv
// Generator of clean, clk-synchronous async clear/preset pulses for downstream
// async-control flops. One request at a time over valid/ready; each request
// gives a PULSE_W-cycle pulse on tgt_clr or tgt_pr, then RELEASE_GAP quiet
// cycles, then a done pulse. System reset passes straight through to tgt_clr.
// Optional q checker is built when ASYNC_CTRL_CHECK_EN is defined.
module async_ctrl_gen
   import async_ctrl_pkg::*;
#(
   parameter int unsigned PULSE_W     = 2,
   parameter int unsigned RELEASE_GAP = 1
) (
   input  logic                  clk,
   input  logic                  clr,
   async_ctrl_gen_if.slave       bus,
   output logic                  tgt_clr,
   output logic                  tgt_pr,
   input  logic                  q_obs,
   output logic                  chk_fail,
   output logic [FAIL_CNT_W-1:0] fail_cnt
);

   localparam int unsigned CW = cnt_width(PULSE_W, RELEASE_GAP);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(RELEASE_GAP - 1);

   // Reject zero-length pulse or gap at elaboration
   if (PULSE_W == 0) begin : g_bad_pulse_w
      $error("async_ctrl_gen: PULSE_W must be >= 1");
   end
   if (RELEASE_GAP == 0) begin : g_bad_release_gap
      $error("async_ctrl_gen: RELEASE_GAP must be >= 1");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   op_e           op_q, op_d;
   logic          tgt_clr_q, tgt_clr_d;
   logic          tgt_pr_q, tgt_pr_d;
   logic          done_q, done_d;
   logic          gap_exit;

   // Sequencer next state; the counter loads on state entry and the state
   // advances when it reaches zero
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      tgt_clr_d = tgt_clr_q;
      tgt_pr_d  = tgt_pr_q;
      done_d    = 1'b0;
      gap_exit  = 1'b0;
      unique case (state_q)
         RST_REL: begin
            // First edge after reset release: drop the passed-through clear
            // synchronously and treat it as a completed clear request
            state_d   = GAP;
            cnt_d     = GAP_LD;
            op_d      = OP_CLR;
            tgt_clr_d = 1'b0;
            tgt_pr_d  = 1'b0;
         end
         IDLE: begin
            if (bus.req_valid) begin
               state_d   = ASSERT;
               cnt_d     = PULSE_LD;
               op_d      = op_e'(bus.req_op);
               tgt_clr_d = ~bus.req_op;
               tgt_pr_d  = bus.req_op;
            end
         end
         ASSERT: begin
            if (cnt_q == '0) begin
               state_d   = GAP;
               cnt_d     = GAP_LD;
               tgt_clr_d = 1'b0;
               tgt_pr_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               gap_exit = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = RST_REL;
         end
      endcase
   end

   // State registers; reset forces the clear through to the target at once
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= RST_REL;
         cnt_q     <= '0;
         op_q      <= OP_CLR;
         tgt_clr_q <= 1'b1;
         tgt_pr_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         tgt_clr_q <= tgt_clr_d;
         tgt_pr_q  <= tgt_pr_d;
         done_q    <= done_d;
      end
   end

   // Status outputs decoded from the registered state
   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.busy      = (state_q != IDLE);
      bus.done      = done_q;
   end

   assign tgt_clr = tgt_clr_q;
   assign tgt_pr  = tgt_pr_q;

`ifdef ASYNC_CTRL_CHECK_EN
   async_ctrl_chk u_chk (
      .clk      (clk),
      .clr      (clr),
      .sample   (gap_exit),
      .op       (op_q),
      .q_obs    (q_obs),
      .chk_fail (chk_fail),
      .fail_cnt (fail_cnt)
   );
`else
   logic unused_chk;
   assign unused_chk = ^{q_obs, gap_exit, op_q};
   assign chk_fail   = 1'b0;
   assign fail_cnt   = '0;
`endif

endmodule

// File: tb/tb_async_ctrl_gen.sv
// Bench for async_ctrl_gen: two instances (default timing and PULSE_W=5 /
// RELEASE_GAP=3) share one random/directed stimulus stream; each is compared
// every cycle against a timeline model of request start/end cycles.
module tb_async_ctrl_gen;
   import async_ctrl_pkg::*;

`ifdef ASYNC_CTRL_CHECK_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic req_valid = 1'b0;
   logic req_op = 1'b0;
   logic q_obs = 1'b0;

   logic [1:0]                 rdy, dn, tc, tp, cf;
   logic [1:0][FAIL_CNT_W-1:0] fc;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int unsigned PW = (g == 0) ? 2 : 5;
      localparam int unsigned RG = (g == 0) ? 1 : 3;

      async_ctrl_gen_if bus();
      logic                  tgt_clr, tgt_pr, chk_fail;
      logic [FAIL_CNT_W-1:0] fail_cnt;

      assign bus.req_valid = req_valid;
      assign bus.req_op    = req_op;

      async_ctrl_gen #(.PULSE_W(PW), .RELEASE_GAP(RG)) dut (
         .clk      (clk),
         .clr      (clr),
         .bus      (bus),
         .tgt_clr  (tgt_clr),
         .tgt_pr   (tgt_pr),
         .q_obs    (q_obs),
         .chk_fail (chk_fail),
         .fail_cnt (fail_cnt)
      );

      assign rdy[g] = bus.req_ready;
      assign dn[g]  = bus.done;
      assign tc[g]  = tgt_clr;
      assign tp[g]  = tgt_pr;
      assign cf[g]  = chk_fail;
      assign fc[g]  = fail_cnt;

      // Model: a sequence starting at edge s with pulse length p keeps the
      // target pulse for edges s..s+p-1 and completes at edge s+p+RG.
      int cyc = 0;
      bit in_rst = 1'b1;
      bit seq = 1'b0;
      bit sop = 1'b0;
      bit mis = 1'b0;
      int start = 0;
      int plen = 0;
      int end_cyc = -10;
      int cnt = 0;

      always @(posedge clk) begin
         cyc++;
         if (clr) begin
            in_rst  = 1'b1;
            seq     = 1'b0;
            cnt     = 0;
            end_cyc = -10;
         end else if (in_rst) begin
            in_rst = 1'b0;
            seq    = 1'b1;
            start  = cyc;
            plen   = 0;
            sop    = 1'b0;
         end else if (seq) begin
            if (cyc - start == int'(plen + RG)) begin
               seq     = 1'b0;
               end_cyc = cyc;
               mis     = CHK_ON && (q_obs != sop);
               if (mis && cnt < 255) cnt++;
            end
         end else if (req_valid) begin
            seq   = 1'b1;
            start = cyc;
            plen  = PW;
            sop   = req_op;
         end
      end

      always @(negedge clk) begin
         bit e_tc, e_tp, e_rdy, e_busy, e_done, e_cf;
         bit on;
         int e_cnt;
         if (clr || in_rst) begin
            e_tc = 1; e_tp = 0; e_rdy = 0; e_busy = 1; e_done = 0; e_cf = 0; e_cnt = 0;
         end else if (seq) begin
            on   = (cyc - start) < plen;
            e_tc = on && !sop; e_tp = on && sop;
            e_rdy = 0; e_busy = 1; e_done = 0; e_cf = 0; e_cnt = cnt;
         end else begin
            e_tc = 0; e_tp = 0; e_rdy = 1; e_busy = 0;
            e_done = (cyc == end_cyc);
            e_cf = e_done && mis; e_cnt = cnt;
         end
         check($sformatf("i%0d tgt_clr", g), int'(tgt_clr), int'(e_tc));
         check($sformatf("i%0d tgt_pr", g), int'(tgt_pr), int'(e_tp));
         check($sformatf("i%0d req_ready", g), int'(bus.req_ready), int'(e_rdy));
         check($sformatf("i%0d busy", g), int'(bus.busy), int'(e_busy));
         check($sformatf("i%0d done", g), int'(bus.done), int'(e_done));
         check($sformatf("i%0d chk_fail", g), int'(chk_fail), int'(e_cf));
         check($sformatf("i%0d fail_cnt", g), int'(fail_cnt), e_cnt);
         check($sformatf("i%0d exclusive", g), int'(tgt_clr && tgt_pr), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      int hold;
      int w;
      int dt;
      bit was;
      bit found;

      // Reset held three cycles, then released
      #1 clr = 1'b1;
      repeat (3) tick();
      check("rst tgt_clr", int'(tc[0]), 1);
      check("rst tgt_pr", int'(tp[0]), 0);
      check("rst ready", int'(rdy[0]), 0);
      clr = 1'b0;
      tick();
      check("rel edge1 tgt_clr", int'(tc[0]), 0);
      check("rel edge1 done", int'(dn[0]), 0);
      tick();
      check("rel edge2 done", int'(dn[0]), 1);
      check("rel edge2 ready", int'(rdy[0]), 1);

      // Preset request with correct q
      req_valid = 1'b1; req_op = 1'b1; q_obs = 1'b1;
      tick();
      req_valid = 1'b0;
      check("pr cyc1 tgt_pr", int'(tp[0]), 1);
      check("pr cyc1 tgt_clr", int'(tc[0]), 0);
      tick();
      check("pr cyc2 tgt_pr", int'(tp[0]), 1);
      tick();
      check("pr cyc3 tgt_pr", int'(tp[0]), 0);
      check("pr cyc3 done", int'(dn[0]), 0);
      tick();
      check("pr done", int'(dn[0]), 1);
      check("pr chk_fail", int'(cf[0]), 0);
      check("pr fail_cnt", int'(fc[0]), 0);

      // Clear requests with q stuck at 1
      req_valid = 1'b1; req_op = 1'b0; q_obs = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         tick();
         if (dn[0]) found = 1'b1;
      end
      check("stuck first done seen", int'(found), 1);
      check("stuck first chk_fail", int'(cf[0]), int'(CHK_ON));
      check("stuck first fail_cnt", int'(fc[0]), CHK_ON ? 1 : 0);
      repeat (1220) tick();
      check("stuck saturated fail_cnt", int'(fc[0]), CHK_ON ? 255 : 0);

      // Back-to-back requests with alternating op
      q_obs = 1'b0;
      prev = -1;
      for (int k = 0; k < 60; k++) begin
         was = rdy[0];
         tick();
         if (was) begin
            check("alt op order", int'(tp[0]), int'(req_op));
            req_op = ~req_op;
         end
         if (dn[0]) begin
            if (prev >= 0) check("alt accept interval", k - prev, 4);
            prev = k;
         end
      end

      // Reset during a preset pulse
      req_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (rdy[0]) found = 1'b1;
         else tick();
      end
      check("abort wait ready", int'(found), 1);
      req_valid = 1'b1; req_op = 1'b1;
      tick();
      req_valid = 1'b0;
      check("abort pulse on", int'(tp[0]), 1);
      clr = 1'b1;
      #1;
      check("abort tgt_pr", int'(tp[0]), 0);
      check("abort tgt_clr", int'(tc[0]), 1);
      tick();
      tick();
      clr = 1'b0;
      tick();
      check("abort rel tgt_clr", int'(tc[0]), 0);
      tick();
      check("abort rel done", int'(dn[0]), 1);

      // Randomized traffic with occasional resets
      hold = 0;
      for (int k = 0; k < 3000; k++) begin
         if (clr) begin
            hold--;
            if (hold == 0) clr = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            clr  = 1'b1;
            hold = $urandom_range(1, 3);
         end
         req_valid = ($urandom_range(0, 3) != 0);
         req_op    = 1'($urandom_range(0, 1));
         q_obs     = 1'($urandom_range(0, 1));
         tick();
      end

      // Long-pulse instance: width and latency
      clr = 1'b0; req_valid = 1'b0; q_obs = 1'b1;
      repeat (2) tick();
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (rdy[1]) found = 1'b1;
         else tick();
      end
      check("long wait ready", int'(found), 1);
      req_valid = 1'b1; req_op = 1'b1;
      tick();
      req_valid = 1'b0;
      w = 0; dt = -1;
      for (int k = 0; k < 20; k++) begin
         if (tp[1]) w++;
         if (dn[1] && dt < 0) dt = k;
         tick();
      end
      check("long pulse width", w, 5);
      check("long accept to done", dt, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
